// File: rtl/ddr_maint_pkg.sv
// Shared types and default timing for the DRAM maintenance (refresh) sequencer.
package ddr_maint_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PREA = 2'd1,
        OP_REF  = 2'd2
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_PREA     = 3'd2,
        ST_WAIT_RP  = 3'd3,
        ST_REF      = 3'd4,
        ST_WAIT_RFC = 3'd5
    } maint_state_e;

    localparam int unsigned T_RP_DEFAULT   = 15;
    localparam int unsigned T_RFC_DEFAULT  = 280;
    localparam int unsigned T_WDOG_DEFAULT = 4096;

    // Timer width wide enough to hold the larger of the two reload values.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/maint_timer.sv
// Load/decrement wait timer shared by the tRP and tRFC waits.
module maint_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Done one cycle before zero so the wait ends exactly N cycles after the load.
    assign o_done = (r_count <= W'(1));

endmodule

// File: rtl/refresh_cmd_issuer.sv
// Refresh command sequencer: drain, optional precharge-all, refresh, then tRFC hold-off.
// Optional REFRESH_WATCHDOG_EN adds a sticky wdog_err output.
//
// state       | meaning
// IDLE        | no maintenance, scheduler free
// DRAIN       | hold scheduler, wait for in-flight burst to finish
// PREA        | present PRECHARGE-ALL until accepted
// WAIT_RP     | tRP wait before refresh
// REF         | present REFRESH until accepted, acknowledge request
// WAIT_RFC    | tRFC wait before releasing the scheduler
module refresh_cmd_issuer
    import ddr_maint_pkg::*;
#(
    parameter int unsigned T_RP   = T_RP_DEFAULT,
    parameter int unsigned T_RFC  = T_RFC_DEFAULT,
    parameter int unsigned T_WDOG = T_WDOG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_cmd,
    output logic       cmd_issued,
    input  logic       rw_busy,
    input  logic       banks_open,
    output logic       maint_hold,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    input  logic       cmd_ready
`ifdef REFRESH_WATCHDOG_EN
    ,
    output logic       wdog_err
`endif
);

    localparam int unsigned TW       = tmr_width(T_RP, T_RFC);
    localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
    // A one-cycle delay needs no wait state at all.
    localparam bit RP_SKIP  = (T_RP == 1);
    localparam bit RFC_SKIP = (T_RFC == 1);

    if (T_RP < 1 || T_RFC < 1 || T_WDOG < 1) begin : g_bad_params
        $error("refresh_cmd_issuer: timing parameters must be at least 1");
    end

    maint_state_e     r_state;
    maint_state_e     w_state_nxt;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_tmr_done;

    maint_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            ST_IDLE:     if (issue_cmd) w_state_nxt = ST_DRAIN;
            ST_DRAIN:    if (!rw_busy) w_state_nxt = banks_open ? ST_PREA : ST_REF;
            ST_PREA: begin
                if (cmd_ready) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = RP_LOAD;
                    w_state_nxt = RP_SKIP ? ST_REF : ST_WAIT_RP;
                end
            end
            ST_WAIT_RP:  if (w_tmr_done) w_state_nxt = ST_REF;
            ST_REF: begin
                if (cmd_ready) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = RFC_LOAD;
                    w_state_nxt = RFC_SKIP ? ST_IDLE : ST_WAIT_RFC;
                end
            end
            ST_WAIT_RFC: if (w_tmr_done) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        maint_hold = (r_state != ST_IDLE);
        cmd_valid  = 1'b0;
        cmd_op     = OP_NOP;
        cmd_issued = 1'b0;
        case (r_state)
            ST_PREA: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_PREA;
            end
            ST_REF: begin
                cmd_valid  = 1'b1;
                cmd_op     = OP_REF;
                cmd_issued = cmd_ready;
            end
            default: ;
        endcase
    end

`ifdef REFRESH_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(T_WDOG + 1);

    logic [WDW-1:0] r_wdog_cnt;
    logic           r_wdog_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else if (r_state == ST_IDLE || cmd_issued) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt == WDW'(T_WDOG - 1)) begin
            r_wdog_err <= 1'b1;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign wdog_err = r_wdog_err;
`endif

endmodule

// File: tb/tb_refresh_cmd_issuer.sv
// Self-checking bench for refresh_cmd_issuer: directed timing cases plus randomized
// traffic against a timestamp-based reference model.
module tb_refresh_cmd_issuer;

    localparam int T_RP   = 15;
    localparam int T_RFC  = 280;
    localparam int T_WDOG = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_cmd;
    logic       cmd_issued;
    logic       rw_busy;
    logic       banks_open;
    logic       maint_hold;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
`ifdef REFRESH_WATCHDOG_EN
    logic       wdog_err;
`endif

    always #5 clk = ~clk;

    refresh_cmd_issuer #(.T_RP(T_RP), .T_RFC(T_RFC), .T_WDOG(T_WDOG)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_cmd  (issue_cmd),
        .cmd_issued (cmd_issued),
        .rw_busy    (rw_busy),
        .banks_open (banks_open),
        .maint_hold (maint_hold),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready)
`ifdef REFRESH_WATCHDOG_EN
        ,
        .wdog_err   (wdog_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a sequence is described by the cycles at which its milestones happened.
    bit m_active    = 1'b0;
    bit m_need_prea = 1'b0;
    int m_drain_end = -1;
    int m_prea_hs   = -1;
    int m_ref_hs    = -1;

    int obs_hold, obs_valid, obs_op, obs_iss;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_cycle(input bit r, input bit iss, input bit busy, input bit bo, input bit rdy);
        int  cmd_start;
        int  ref_first;
        bit  in_prea;
        bit  in_ref;
        @(negedge clk);
        rst        = r;
        issue_cmd  = iss;
        rw_busy    = busy;
        banks_open = bo;
        cmd_ready  = rdy;
        #1;
        in_prea   = 1'b0;
        in_ref    = 1'b0;
        ref_first = -1;
        if (m_active && m_drain_end >= 0) begin
            cmd_start = m_drain_end + 1;
            if (m_need_prea) begin
                in_prea   = (cyc >= cmd_start) && (m_prea_hs < 0 || cyc <= m_prea_hs);
                ref_first = (m_prea_hs < 0) ? -1 : m_prea_hs + T_RP;
            end else begin
                ref_first = cmd_start;
            end
            in_ref = (ref_first >= 0) && (cyc >= ref_first) && (m_ref_hs < 0 || cyc <= m_ref_hs);
        end
        obs_hold  = int'(maint_hold);
        obs_valid = int'(cmd_valid);
        obs_op    = int'(cmd_op);
        obs_iss   = int'(cmd_issued);
        check("maint_hold", obs_hold, int'(m_active));
        check("cmd_valid", obs_valid, int'(in_prea || in_ref));
        check("cmd_op", obs_op, in_prea ? 1 : (in_ref ? 2 : 0));
        check("cmd_issued", obs_iss, int'(in_ref && rdy));
        if (r) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (iss) begin
                m_active    = 1'b1;
                m_drain_end = -1;
                m_prea_hs   = -1;
                m_ref_hs    = -1;
            end
        end else begin
            if (m_drain_end < 0) begin
                if (!busy) begin
                    m_drain_end = cyc;
                    m_need_prea = bo;
                end
            end else if (in_prea && rdy) begin
                m_prea_hs = cyc;
            end else if (in_ref && rdy) begin
                m_ref_hs = cyc;
            end
            if (m_ref_hs >= 0 && cyc == m_ref_hs + T_RFC - 1) m_active = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        bit pend;
        int first_prea, first_ref, first_iss, release_at, n_pulse;

        rst = 1'b1; issue_cmd = 1'b0; rw_busy = 1'b0; banks_open = 1'b0; cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 1);

        // Default timing: PREA at 2, REF/ack at 17, release at 297.
        pend = 1'b1; first_prea = -1; first_iss = -1; release_at = -1; n_pulse = 0;
        for (int i = 0; i < 310; i++) begin
            run_cycle(0, pend, 0, 1, 1);
            if (obs_op == 1 && first_prea < 0) first_prea = i;
            if (obs_iss == 1) begin
                if (first_iss < 0) first_iss = i;
                n_pulse++;
                pend = 1'b0;
            end
            if (i > 0 && obs_hold == 0 && release_at < 0) release_at = i;
        end
        check("prea_cycle", first_prea, 2);
        check("ack_cycle", first_iss, 17);
        check("release_cycle", release_at, 297);
        check("ack_pulses", n_pulse, 1);

        // No open banks and a 5-cycle PHY stall on REF.
        pend = 1'b1; first_prea = -1; first_ref = -1; first_iss = -1; n_pulse = 0;
        for (int i = 0; i < 300; i++) begin
            run_cycle(0, pend, 0, 0, !(i >= 2 && i <= 6));
            if (obs_op == 1 && first_prea < 0) first_prea = i;
            if (obs_op == 2 && first_ref < 0) first_ref = i;
            if (obs_iss == 1) begin
                if (first_iss < 0) first_iss = i;
                n_pulse++;
                pend = 1'b0;
            end
        end
        check("no_prea", first_prea, -1);
        check("ref_after_drain", first_ref, 2);
        check("stall_ack_cycle", first_iss, 7);
        check("stall_ack_pulses", n_pulse, 1);

        // Read/write path busy while draining.
        pend = 1'b1;
        for (int i = 0; i < 320; i++) begin
            run_cycle(0, pend, i <= 10, 1, 1);
            if (obs_iss == 1) pend = 1'b0;
        end

        // Reset mid-tRFC with the request still held.
        for (int i = 0; i < 104; i++) begin
            run_cycle(i == 100, 1, 0, 1, 1);
            if (i == 101) check("rst_hold", obs_hold, 0);
            if (i == 102) check("restart_hold", obs_hold, 1);
        end
        for (int i = 0; i < 320; i++) run_cycle(0, 0, 0, 1, 1);

        // Randomized traffic.
        pend = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            bit r;
            r = ($urandom_range(999) < 2);
            if (!pend && $urandom_range(99) < 5) pend = 1'b1;
            else if (pend && $urandom_range(99) < 2) pend = 1'b0;
            run_cycle(r, pend, $urandom_range(99) < 30, $urandom_range(1), $urandom_range(99) < 60);
            if (obs_iss == 1 && $urandom_range(99) < 70) pend = 1'b0;
        end

`ifdef REFRESH_WATCHDOG_EN
        run_cycle(1, 0, 0, 1, 1);
        check("wdog_reset", int'(wdog_err), 0);
        for (int i = 0; i < 30; i++) begin
            run_cycle(0, 1, 1, 1, 1);
            check("wdog_err", int'(wdog_err), int'(i >= 17));
        end
        run_cycle(1, 0, 1, 1, 1);
        run_cycle(0, 0, 0, 1, 1);
        check("wdog_cleared", int'(wdog_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
